// File: rtl/dec_digit_entry.sv
// Keypad number entry: accumulates decimal digits and a sign into a signed operand
// and pushes it over valid/ready. Define ENTRY_SATURATE_EN to clamp instead of reject on overflow.
module dec_digit_entry #(
    parameter int unsigned W          = 8,
    parameter int unsigned MAX_DIGITS = 3,
    localparam int unsigned NW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          digit_valid,
    input  logic [3:0]    digit,
    input  logic          neg_key,
    input  logic          enter_key,
    input  logic          clear_key,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  entry_mag,
    output logic          entry_neg,
    output logic          entry_active,
    output logic [NW-1:0] ndigits,
    output logic          err
);

    localparam int unsigned XW = W + 4;

    typedef enum logic [1:0] {StIdle, StEntry, StPush} state_t;
    state_t state;

    logic [XW-1:0] next_mag;
    logic [XW-1:0] limit;
    logic          digit_bad;
    logic          digits_full;
    logic          over_limit;
    logic          neg_bad;
    logic [NW-1:0] nd_inc;
    logic [W-1:0]  signed_val;

    // Negative entries may reach 2^(W-1); positive ones stop one short.
    assign limit       = entry_neg ? {4'b0, 1'b1, {(W-1){1'b0}}} : {5'b0, {(W-1){1'b1}}};
    assign next_mag    = {4'b0, entry_mag} * XW'(10) + {{W{1'b0}}, digit};
    assign digit_bad   = digit > 4'd9;
    assign digits_full = ndigits == NW'(MAX_DIGITS);
    assign over_limit  = next_mag > limit;
    assign neg_bad     = entry_neg && (entry_mag == {1'b1, {(W-1){1'b0}}});
    assign nd_inc      = ndigits + NW'(1);
    assign signed_val  = entry_neg ? -entry_mag : entry_mag;

    assign entry_active = state == StEntry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            out_data  <= '0;
            out_valid <= 1'b0;
            entry_mag <= '0;
            entry_neg <= 1'b0;
            ndigits   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                StPush: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    if (clear_key) begin
                        entry_mag <= '0;
                        entry_neg <= 1'b0;
                        ndigits   <= '0;
                        err       <= 1'b0;
                        state     <= StIdle;
                    end else if (enter_key) begin
                        if (ndigits != '0) begin
                            out_data  <= signed_val;
                            out_valid <= 1'b1;
                            err       <= 1'b0;
                            entry_mag <= '0;
                            entry_neg <= 1'b0;
                            ndigits   <= '0;
                            state     <= StPush;
                        end
                    end else if (neg_key) begin
                        if (neg_bad) begin
                            err <= 1'b1;
`ifdef ENTRY_SATURATE_EN
                            entry_mag <= {1'b0, {(W-1){1'b1}}};
                            entry_neg <= 1'b0;
`endif
                        end else begin
                            entry_neg <= ~entry_neg;
                            state     <= StEntry;
                        end
                    end else if (digit_valid) begin
                        if (digit_bad || digits_full) begin
                            err <= 1'b1;
                        end else if (over_limit) begin
                            err <= 1'b1;
`ifdef ENTRY_SATURATE_EN
                            entry_mag <= limit[W-1:0];
                            ndigits   <= nd_inc;
                            state     <= StEntry;
`endif
                        end else begin
                            entry_mag <= next_mag[W-1:0];
                            ndigits   <= nd_inc;
                            state     <= StEntry;
                        end
                    end
                end
            endcase
        end
    end

endmodule
